wm_plant_responder: RTL and testbench
=====================================

Name: wm_plant_responder

Overview:
- Plant-side responder for the washing-machine controller. Consumes the controller's operation commands and returns the status signals the controller waits on: sig_Full, sig_Temperature, sig_Completed and sig_Time_Out.
- Replaces the physical drum, heater and motor in simulation and on FPGA bring-up. It times each phase with a counter and enforces a watchdog.

Parameters:
- FILL_CYCLES, 8, counted cycles (water_Intake high) to fill the drum
- HEAT_CYCLES, 6, cycles to reach temperature
- WASH_CYCLES, 12, cycles of wash
- RINSE_CYCLES, 10, cycles of rinse
- SPIN_CYCLES, 8, cycles of spin (drains drum)
- TIMEOUT_CYCLES, 32, watchdog limit per phase; must exceed every phase length
- CNT_W, 8, width of phase and watchdog counters

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- fill_Water_Operation  input  1  fill command (level)
- heat_Water_Operation  input  1  heat command (level)
- wash_Operation  input  1  wash command (level)
- rinse_Operation  input  1  rinse command (level)
- spin_Operation  input  1  spin command (level)
- water_Intake  input  1  inlet valve open; gates fill counting
- sig_Full  output  1  drum full (sticky level)
- sig_Temperature  output  1  water at temperature (sticky level)
- sig_Completed  output  1  one-cycle pulse at end of wash, rinse or spin
- sig_Time_Out  output  1  watchdog expired (level)
- cmd_Error  output  1  more than one command high (registered level)
- phase  output  3  responder state code

Behaviour:
- Reset (async, any time, including mid-phase): state IDLE, both counters 0, all outputs 0, phase=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State codes on phase: IDLE=0, FILL=1, HEAT=2, WASH=3, RINSE=4, SPIN=5, DONE=6, TIMEOUT=7.
- Command validity:
  - cmd_Error is registered high on any edge where two or more commands are high.
  - While cmd_Error conditions persist, the state is forced to IDLE and the counters are cleared.
  - cmd_Error clears on the first edge where at most one command is high.
- IDLE: on an edge where exactly one command is high, go to the matching phase state. Phase counter and watchdog are cleared to 0.
- Phase states:
  - Each edge with the command still high increments the watchdog.
  - The phase counter increments every edge, except in FILL, where it increments only when water_Intake=1.
  - Completion happens on the edge where the phase counter would reach LEN, so the output is visible LEN edges after the entry edge (fill: LEN counted edges).
  - On completion, go to DONE.
- Completion effects:
  - FILL sets sig_Full=1.
  - HEAT sets sig_Temperature=1.
  - WASH and RINSE pulse sig_Completed for exactly one cycle.
  - SPIN pulses sig_Completed and clears sig_Full.
  - Entering RINSE clears sig_Temperature (cold rinse).
- Abort: if the active command drops before completion, return to IDLE next edge. Counters clear, no completion effect, and sticky flags keep their values.
- DONE: hold while any command is high. Return to IDLE on the first edge with all commands low. A new, different command while in DONE is ignored until IDLE is reached.
- Watchdog: if it reaches TIMEOUT_CYCLES before completion, go to TIMEOUT and set sig_Time_Out=1. If completion and timeout fall on the same edge, completion wins.
- TIMEOUT: sig_Time_Out stays high until an edge with all commands low. That edge clears it and returns to IDLE.
- Counters saturate and never wrap.

Test Plan:
- Fill: reset, fill_Water_Operation=1 and water_Intake=1 held -> phase=1 after edge 0, sig_Full rises after edge 8, phase=6; drop command -> phase=0 next edge, sig_Full stays 1.
- Gated fill: water_Intake toggles 1/0 each cycle -> sig_Full rises after 16 edges. Hold water_Intake=0 -> sig_Time_Out=1 after 32 edges, phase=7; drop command -> sig_Time_Out=0, phase=0.
- Full cycle: fill, heat, wash, rinse, spin in sequence, each command dropped after its completion -> sig_Temperature=1 after 6 heat edges and 0 on rinse entry; sig_Completed pulses exactly 1 cycle at 12, 10 and 8 edges into wash, rinse and spin; sig_Full=0 after spin.
- Abort: wash_Operation dropped at edge 5 -> phase=0, no sig_Completed pulse; reissue -> full 12 edges required.
- Error: wash_Operation and rinse_Operation both high -> cmd_Error=1, phase=0; drop rinse -> cmd_Error=0, WASH entered.
- Reset mid-heat at edge 3, asserted between clock edges -> all outputs 0 immediately, without waiting for a clock edge; phase=0.

Source files
------------

// File: rtl/wm_plant_responder_if.sv
// Command/status bundle between the washing-machine controller
// and the plant-side responder.
interface wm_plant_responder_if;
  logic       fill_Water_Operation;
  logic       heat_Water_Operation;
  logic       wash_Operation;
  logic       rinse_Operation;
  logic       spin_Operation;
  logic       water_Intake;
  logic       sig_Full;
  logic       sig_Temperature;
  logic       sig_Completed;
  logic       sig_Time_Out;
  logic       cmd_Error;
  logic [2:0] phase;

  modport master (
    output fill_Water_Operation,
    output heat_Water_Operation,
    output wash_Operation,
    output rinse_Operation,
    output spin_Operation,
    output water_Intake,
    input  sig_Full,
    input  sig_Temperature,
    input  sig_Completed,
    input  sig_Time_Out,
    input  cmd_Error,
    input  phase
  );

  modport slave (
    input  fill_Water_Operation,
    input  heat_Water_Operation,
    input  wash_Operation,
    input  rinse_Operation,
    input  spin_Operation,
    input  water_Intake,
    output sig_Full,
    output sig_Temperature,
    output sig_Completed,
    output sig_Time_Out,
    output cmd_Error,
    output phase
  );
endinterface

// File: rtl/wm_plant_responder.sv
// Plant model for the washing-machine controller: times each
// phase with a counter and guards it with a watchdog.
module wm_plant_responder #(
  parameter int FILL_CYCLES    = 8,
  parameter int HEAT_CYCLES    = 6,
  parameter int WASH_CYCLES    = 12,
  parameter int RINSE_CYCLES   = 10,
  parameter int SPIN_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_W          = 8
) (
  input logic clock,
  input logic reset,
  wm_plant_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_HEAT    = 3'd2,
    S_WASH    = 3'd3,
    S_RINSE   = 3'd4,
    S_SPIN    = 3'd5,
    S_DONE    = 3'd6,
    S_TIMEOUT = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             full_q, full_d;
  logic             temp_q, temp_d;
  logic             cmp_q, cmp_d;
  logic             to_q, to_d;
  logic             err_q, err_d;

  logic [4:0]       cmd;
  logic             multi;
  logic             one;
  logic             act;
  logic             pc_en;
  logic [CNT_W-1:0] last;

  assign cmd = {bus.spin_Operation, bus.rinse_Operation,
                bus.wash_Operation, bus.heat_Water_Operation,
                bus.fill_Water_Operation};

  // Two or more bits set <=> clearing the lowest set bit leaves some
  assign multi = (cmd & (cmd - 5'd1)) != 5'd0;
  assign one   = (cmd != 5'd0) && !multi;

  always_comb begin
    act   = 1'b0;
    last  = CNT_MAX;
    pc_en = 1'b1;
    case (state_q)
      S_FILL: begin
        act   = cmd[0];
        last  = FILL_LAST;
        pc_en = bus.water_Intake;
      end
      S_HEAT:  begin act = cmd[1]; last = HEAT_LAST;  end
      S_WASH:  begin act = cmd[2]; last = WASH_LAST;  end
      S_RINSE: begin act = cmd[3]; last = RINSE_LAST; end
      S_SPIN:  begin act = cmd[4]; last = SPIN_LAST;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wd_d    = wd_q;
    full_d  = full_q;
    temp_d  = temp_q;
    cmp_d   = 1'b0;
    to_d    = to_q;
    err_d   = multi;
    if (multi) begin
      state_d = S_IDLE;
      pc_d    = '0;
      wd_d    = '0;
      to_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          pc_d = '0;
          wd_d = '0;
          if (one) begin
            unique case (1'b1)
              cmd[0]: state_d = S_FILL;
              cmd[1]: state_d = S_HEAT;
              cmd[2]: state_d = S_WASH;
              cmd[3]: begin
                state_d = S_RINSE;
                temp_d  = 1'b0;
              end
              cmd[4]: state_d = S_SPIN;
            endcase
          end
        end
        S_FILL, S_HEAT, S_WASH, S_RINSE, S_SPIN: begin
          if (!act) begin
            state_d = S_IDLE;
            pc_d    = '0;
            wd_d    = '0;
          end else if (pc_en && pc_q == last) begin
            // Completion beats a watchdog expiry on the same edge
            state_d = S_DONE;
            pc_d    = '0;
            wd_d    = '0;
            unique case (state_q)
              S_FILL:  full_d = 1'b1;
              S_HEAT:  temp_d = 1'b1;
              S_SPIN: begin
                cmp_d  = 1'b1;
                full_d = 1'b0;
              end
              default: cmp_d = 1'b1;
            endcase
          end else if (wd_q == WD_LAST) begin
            state_d = S_TIMEOUT;
            to_d    = 1'b1;
            pc_d    = '0;
            wd_d    = '0;
          end else begin
            if (pc_en && pc_q != CNT_MAX) pc_d = pc_q + 1'b1;
            if (wd_q != CNT_MAX) wd_d = wd_q + 1'b1;
          end
        end
        S_DONE: begin
          if (cmd == 5'd0) state_d = S_IDLE;
        end
        S_TIMEOUT: begin
          if (cmd == 5'd0) begin
            state_d = S_IDLE;
            to_d    = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wd_q    <= '0;
      full_q  <= 1'b0;
      temp_q  <= 1'b0;
      cmp_q   <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wd_q    <= wd_d;
      full_q  <= full_d;
      temp_q  <= temp_d;
      cmp_q   <= cmp_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign bus.sig_Full        = full_q;
  assign bus.sig_Temperature = temp_q;
  assign bus.sig_Completed   = cmp_q;
  assign bus.sig_Time_Out    = to_q;
  assign bus.cmd_Error       = err_q;
  assign bus.phase           = state_q;

endmodule

// File: tb/tb_wm_plant_responder.sv
// Directed bench for wm_plant_responder: phase timing, gating,
// watchdog, abort, command error and asynchronous reset.
module tb_wm_plant_responder;

  logic clock;
  logic reset;
  int   nvec;
  int   nerr;

  wm_plant_responder_if bus ();

  wm_plant_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cmds(input logic [4:0] c);
    bus.fill_Water_Operation = c[0];
    bus.heat_Water_Operation = c[1];
    bus.wash_Operation       = c[2];
    bus.rinse_Operation      = c[3];
    bus.spin_Operation       = c[4];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b1;
    cmds(5'b00000);
    bus.water_Intake = 1'b0;
    tick(2);
    chk("rst_phase", 8'(bus.phase), 8'd0);
    chk("rst_full", 8'(bus.sig_Full), 8'd0);
    chk("rst_to", 8'(bus.sig_Time_Out), 8'd0);
    reset = 1'b0;
    tick(1);

    // Fill with inlet open
    cmds(5'b00001);
    bus.water_Intake = 1'b1;
    tick(1);
    chk("fill_enter", 8'(bus.phase), 8'd1);
    tick(7);
    chk("fill_e7", 8'(bus.sig_Full), 8'd0);
    tick(1);
    chk("fill_e8", 8'(bus.sig_Full), 8'd1);
    chk("fill_done", 8'(bus.phase), 8'd6);
    cmds(5'b00000);
    tick(1);
    chk("fill_idle", 8'(bus.phase), 8'd0);
    chk("fill_sticky", 8'(bus.sig_Full), 8'd1);

    // Gated fill: inlet open on even edges only
    do_reset();
    cmds(5'b00001);
    tick(1);
    for (int k = 1; k <= 15; k++) begin
      bus.water_Intake = (k % 2 == 0);
      tick(1);
    end
    chk("gfill_e15", 8'(bus.sig_Full), 8'd0);
    bus.water_Intake = 1'b1;
    tick(1);
    chk("gfill_e16", 8'(bus.sig_Full), 8'd1);
    cmds(5'b00000);
    tick(1);

    // Watchdog: inlet closed
    bus.water_Intake = 1'b0;
    cmds(5'b00001);
    tick(1);
    tick(31);
    chk("to_e31", 8'(bus.sig_Time_Out), 8'd0);
    tick(1);
    chk("to_e32", 8'(bus.sig_Time_Out), 8'd1);
    chk("to_phase", 8'(bus.phase), 8'd7);
    tick(2);
    chk("to_hold", 8'(bus.sig_Time_Out), 8'd1);
    cmds(5'b00000);
    tick(1);
    chk("to_clr", 8'(bus.sig_Time_Out), 8'd0);
    chk("to_idle", 8'(bus.phase), 8'd0);

    // Full cycle
    do_reset();
    bus.water_Intake = 1'b1;
    cmds(5'b00001);
    tick(9);
    chk("cyc_full", 8'(bus.sig_Full), 8'd1);
    cmds(5'b00000);
    tick(1);
    cmds(5'b00010);
    tick(1);
    chk("heat_enter", 8'(bus.phase), 8'd2);
    tick(5);
    chk("heat_e5", 8'(bus.sig_Temperature), 8'd0);
    tick(1);
    chk("heat_e6", 8'(bus.sig_Temperature), 8'd1);
    cmds(5'b00000);
    tick(1);
    cmds(5'b00100);
    tick(12);
    chk("wash_e11", 8'(bus.sig_Completed), 8'd0);
    tick(1);
    chk("wash_e12", 8'(bus.sig_Completed), 8'd1);
    tick(1);
    chk("wash_pulse", 8'(bus.sig_Completed), 8'd0);
    chk("wash_done", 8'(bus.phase), 8'd6);
    cmds(5'b00000);
    tick(1);
    cmds(5'b01000);
    tick(1);
    chk("rinse_enter", 8'(bus.phase), 8'd4);
    chk("rinse_cold", 8'(bus.sig_Temperature), 8'd0);
    tick(9);
    chk("rinse_e9", 8'(bus.sig_Completed), 8'd0);
    tick(1);
    chk("rinse_e10", 8'(bus.sig_Completed), 8'd1);
    tick(1);
    chk("rinse_pulse", 8'(bus.sig_Completed), 8'd0);
    cmds(5'b00000);
    tick(1);
    cmds(5'b10000);
    tick(8);
    chk("spin_e7", 8'(bus.sig_Completed), 8'd0);
    tick(1);
    chk("spin_e8", 8'(bus.sig_Completed), 8'd1);
    chk("spin_drain", 8'(bus.sig_Full), 8'd0);
    tick(1);
    chk("spin_pulse", 8'(bus.sig_Completed), 8'd0);
    cmds(5'b00000);
    tick(1);

    // Abort wash at edge 5, then reissue
    cmds(5'b00100);
    tick(5);
    cmds(5'b00000);
    tick(1);
    chk("abort_idle", 8'(bus.phase), 8'd0);
    chk("abort_nocmp", 8'(bus.sig_Completed), 8'd0);
    cmds(5'b00100);
    tick(12);
    chk("reiss_e11", 8'(bus.sig_Completed), 8'd0);
    tick(1);
    chk("reiss_e12", 8'(bus.sig_Completed), 8'd1);
    cmds(5'b00000);
    tick(1);

    // Command conflict
    cmds(5'b01100);
    tick(1);
    chk("err_set", 8'(bus.cmd_Error), 8'd1);
    chk("err_idle", 8'(bus.phase), 8'd0);
    tick(1);
    chk("err_hold", 8'(bus.phase), 8'd0);
    cmds(5'b00100);
    tick(1);
    chk("err_clr", 8'(bus.cmd_Error), 8'd0);
    chk("err_wash", 8'(bus.phase), 8'd3);
    cmds(5'b00000);
    tick(1);

    // Async reset mid-heat, with sig_Full set beforehand
    cmds(5'b00001);
    tick(9);
    cmds(5'b00000);
    tick(1);
    cmds(5'b00010);
    tick(4);
    chk("mid_heat", 8'(bus.phase), 8'd2);
    chk("mid_full", 8'(bus.sig_Full), 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_phase", 8'(bus.phase), 8'd0);
    chk("arst_full", 8'(bus.sig_Full), 8'd0);
    chk("arst_temp", 8'(bus.sig_Temperature), 8'd0);
    chk("arst_err", 8'(bus.cmd_Error), 8'd0);
    cmds(5'b00000);
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("post_rst", 8'(bus.phase), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
